// File: rtl/watch_pkg.sv
// Shared types and default timing constants for the watch time-setting front end.
package watch_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } set_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_TIMEOUT_CYCLES  = 64;
    localparam int DEF_REPEAT_DELAY    = 16;
    localparam int DEF_REPEAT_PERIOD   = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/watch_set_if.sv
// Time-setting command bundle from the controller to the hour/minute counters.
interface watch_set_if;

    // valid_response is a one-cycle strobe with no ready/backpressure: the consumer
    // must accept it in the cycle it is high; mode/change_* are levels stable around it.
    logic       mode;
    logic       change_hour;
    logic       change_min;
    logic       valid_response;
    logic [1:0] set_state;

    modport master (
        output mode,
        output change_hour,
        output change_min,
        output valid_response,
        output set_state
    );

    modport slave (
        input mode,
        input change_hour,
        input change_min,
        input valid_response,
        input set_state
    );

endinterface

// File: rtl/watch_set_ctrl_btn_debounce.sv
// Raw push-button conditioning: 2-flop synchroniser, stable-sample debounce, rising-edge pulse.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level_q;

    // The counter only runs while the synchronised sample disagrees with the
    // accepted level, so it tops out at DEBOUNCE_CYCLES-1 and never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= 2'b00;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            level_q <= level;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/watch_set_ctrl.sv
// RUN -> SET_HOUR -> SET_MIN -> RUN setting controller with idle timeout.
// Auto-repeat of held INC is built only when WATCH_SET_AUTO_REPEAT_EN is defined.
module watch_set_ctrl
    import watch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_mode,
    input  logic               btn_inc,
    watch_set_if.master        cmd
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          mode_level, mode_press;
    logic          inc_level, inc_press;
    logic          inc_fire;
    logic          in_set, in_set_nx, timeout, strobe_nx;
    logic          unused_levels;
    set_state_t    state, state_nx;
    logic [TW-1:0] idle_cnt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_mode),
        .level (mode_level),
        .press (mode_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_inc),
        .level (inc_level),
        .press (inc_press)
    );

    assign unused_levels = ^{mode_level, inc_level};

    assign in_set    = (state == SET_HOUR) || (state == SET_MIN);
    assign in_set_nx = (state_nx == SET_HOUR) || (state_nx == SET_MIN);
    assign timeout   = in_set && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef WATCH_SET_AUTO_REPEAT_EN
    localparam int RW = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    logic          rep_active, rep_first, rep_fire;
    logic [RW-1:0] rep_cnt;

    // Repeats only follow a real INC strobe; a level held into a SET state never arms them.
    assign rep_fire = rep_active && inc_level && in_set &&
                      (rep_first ? (rep_cnt == RW'(REPEAT_DELAY - 1))
                                 : (rep_cnt == RW'(REPEAT_PERIOD - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rep_active <= 1'b0;
            rep_first  <= 1'b0;
            rep_cnt    <= '0;
        end else if (!inc_level || mode_press || !in_set_nx) begin
            rep_active <= 1'b0;
            rep_first  <= 1'b0;
            rep_cnt    <= '0;
        end else if (inc_press) begin
            rep_active <= 1'b1;
            rep_first  <= 1'b1;
            rep_cnt    <= '0;
        end else if (rep_fire) begin
            rep_first <= 1'b0;
            rep_cnt   <= '0;
        end else if (rep_active && (rep_cnt != RW'(max2(REPEAT_DELAY, REPEAT_PERIOD)))) begin
            rep_cnt <= rep_cnt + RW'(1);
        end
    end

    assign inc_fire = inc_press | rep_fire;
`else
    assign inc_fire = inc_press;
`endif

    // Priority inside a SET state: MODE press, then increment, then timeout.
    always_comb begin
        state_nx  = state;
        strobe_nx = 1'b0;
        case (state)
            RUN: begin
                if (mode_press) state_nx = SET_HOUR;
            end
            SET_HOUR: begin
                if (mode_press)    state_nx  = SET_MIN;
                else if (inc_fire) strobe_nx = 1'b1;
                else if (timeout)  state_nx  = RUN;
            end
            SET_MIN: begin
                if (mode_press)    state_nx  = RUN;
                else if (inc_fire) strobe_nx = 1'b1;
                else if (timeout)  state_nx  = RUN;
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= RUN;
            idle_cnt           <= '0;
            cmd.mode           <= 1'b0;
            cmd.change_hour    <= 1'b0;
            cmd.change_min     <= 1'b0;
            cmd.valid_response <= 1'b0;
        end else begin
            state              <= state_nx;
            cmd.mode           <= in_set_nx;
            cmd.change_hour    <= (state_nx == SET_HOUR);
            cmd.change_min     <= (state_nx == SET_MIN);
            cmd.valid_response <= strobe_nx;
            if (!in_set_nx || (state_nx != state) || mode_press || inc_fire) begin
                idle_cnt <= '0;
            end else if (!timeout) begin
                idle_cnt <= idle_cnt + TW'(1);
            end
        end
    end

    assign cmd.set_state = state;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Scoreboard bench for watch_set_ctrl: directed button sequences, event queue, timing probes.
module tb_watch_set_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_mode = 1'b0;
    logic btn_inc = 1'b0;

    watch_set_if cmd();

    watch_set_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .cmd      (cmd)
    );

    always #5 clk = ~clk;

    // Event word: {valid_response, mode, change_hour, change_min, set_state[1:0]}
    localparam logic [5:0] EV_RUN   = 6'b0_0_0_0_00;
    localparam logic [5:0] EV_HOUR  = 6'b0_1_1_0_01;
    localparam logic [5:0] EV_MIN   = 6'b0_1_0_1_10;
    localparam logic [5:0] EV_INC_H = 6'b1_1_1_0_01;

    logic [5:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int hour  = 22;

    logic [5:0] ev;
    logic [1:0] prev_ss = 2'd0;
    logic       prev_vr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_mode(input int hi, input int lo);
        btn_mode = 1'b1;
        tick(hi);
        btn_mode = 1'b0;
        tick(lo);
    endtask

    task automatic pulse_inc(input int hi, input int lo);
        btn_inc = 1'b1;
        tick(hi);
        btn_inc = 1'b0;
        tick(lo);
    endtask

    // Hour counter consumer, advanced only by a qualified increment.
    always @(posedge clk) begin
        if (cmd.mode && cmd.change_hour && cmd.valid_response)
            hour <= (hour == 23) ? 0 : hour + 1;
    end

    // Monitor: any strobe or state change is an event and must match the queue head.
    always @(negedge clk) begin
        ev = {cmd.valid_response, cmd.mode, cmd.change_hour, cmd.change_min, cmd.set_state};
        if (cmd.valid_response) begin
            check("strobe_in_run", 32'(cmd.set_state != 2'd0), 32'd1);
            check("strobe_back_to_back", 32'(prev_vr), 32'd0);
        end
        if (cmd.valid_response || (cmd.set_state != prev_ss)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_event: got %b expected none", ev);
            end else begin
                check("event", 32'(ev), 32'(exp_q.pop_front()));
            end
        end
        prev_ss = cmd.set_state;
        prev_vr = cmd.valid_response;
    end

    initial begin
        // Reset state
        tick(3);
        check("rst_set_state", 32'(cmd.set_state), 32'd0);
        check("rst_mode", 32'(cmd.mode), 32'd0);
        check("rst_change_hour", 32'(cmd.change_hour), 32'd0);
        check("rst_change_min", 32'(cmd.change_min), 32'd0);
        check("rst_valid_response", 32'(cmd.valid_response), 32'd0);

        // MODE held 10 cycles from reset release: SET_HOUR exactly at edge 7
        rst = 1'b0;
        btn_mode = 1'b1;
        exp_q.push_back(EV_HOUR);
        tick(6);
        check("latency_before", 32'(cmd.set_state), 32'd0);
        tick(1);
        check("latency_state", 32'(cmd.set_state), 32'd1);
        check("latency_mode", 32'(cmd.mode), 32'd1);
        check("latency_change_hour", 32'(cmd.change_hour), 32'd1);
        check("latency_no_strobe", 32'(cmd.valid_response), 32'd0);
        tick(3);
        btn_mode = 1'b0;
        tick(10);

        // Three clean INC presses: hour 22 -> 23 -> 0 -> 1
        exp_q.push_back(EV_INC_H);
        pulse_inc(8, 8);
        check("hour_press1", 32'(hour), 32'd23);
        exp_q.push_back(EV_INC_H);
        pulse_inc(8, 8);
        check("hour_press2", 32'(hour), 32'd0);
        exp_q.push_back(EV_INC_H);
        pulse_inc(8, 8);
        check("hour_press3", 32'(hour), 32'd1);

        // Bounce 1-0-1-0 in 2-cycle pulses is rejected; a 6-cycle hold is accepted once
        pulse_inc(2, 2);
        pulse_inc(2, 2);
        exp_q.push_back(EV_INC_H);
        pulse_inc(6, 10);
        check("hour_after_bounce", 32'(hour), 32'd2);

        // MODE and INC together in SET_HOUR: MODE wins, no strobe
        exp_q.push_back(EV_MIN);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        tick(8);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick(10);
        check("hour_after_simul", 32'(hour), 32'd2);

        // MODE wraps SET_MIN -> RUN -> SET_HOUR -> SET_MIN, then idle timeout
        exp_q.push_back(EV_RUN);
        pulse_mode(8, 8);
        exp_q.push_back(EV_HOUR);
        pulse_mode(8, 8);
        exp_q.push_back(EV_MIN);
        pulse_mode(8, 8);
        exp_q.push_back(EV_RUN);
        tick(54);
        check("timeout_before", 32'(cmd.set_state), 32'd2);
        tick(1);
        check("timeout_state", 32'(cmd.set_state), 32'd0);
        check("timeout_mode", 32'(cmd.mode), 32'd0);
        check("timeout_change_hour", 32'(cmd.change_hour), 32'd0);
        check("timeout_change_min", 32'(cmd.change_min), 32'd0);

        // Asynchronous reset mid-press in SET_MIN
        exp_q.push_back(EV_HOUR);
        pulse_mode(8, 8);
        exp_q.push_back(EV_MIN);
        pulse_mode(8, 8);
        btn_inc = 1'b1;
        tick(3);
        exp_q.push_back(EV_RUN);
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", 32'(cmd.set_state), 32'd0);
        check("async_rst_mode", 32'(cmd.mode), 32'd0);
        check("async_rst_change_min", 32'(cmd.change_min), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(12);
        // INC still held into SET_HOUR must not strobe until released and re-pressed
        exp_q.push_back(EV_HOUR);
        pulse_mode(8, 8);
        btn_inc = 1'b0;
        tick(10);
        check("hour_held_through_rst", 32'(hour), 32'd2);
        exp_q.push_back(EV_INC_H);
        pulse_inc(8, 8);
        check("hour_after_repress", 32'(hour), 32'd3);

`ifdef WATCH_SET_AUTO_REPEAT_EN
        // Held 40 cycles: strobes at t0, t0+16, t0+20, ... t0+36
        repeat (7) exp_q.push_back(EV_INC_H);
        pulse_inc(40, 10);
        check("hour_after_repeat", 32'(hour), 32'd10);
`endif

        for (int i = 0; (i < 200) && (exp_q.size() != 0); i++) tick(1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/watch_set_ctrl.md
Name: watch_set_ctrl

Overview:
- Front-end controller that produces the time-setting command interface consumed by the hour and minute counters: `mode`, `change_hour`, `change_min` and the `valid_response` strobe.
- Synchronises and debounces two raw push-buttons (MODE, INC).
- Walks an RUN -> SET_HOUR -> SET_MIN -> RUN state machine.
- Issues exactly one single-cycle `valid_response` per accepted increment, with optional auto-repeat.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples required before a button level is accepted (min 1).
- TIMEOUT_CYCLES, 64, idle cycles in a SET state before automatic return to RUN.
- REPEAT_DELAY, 16, hold cycles before the first auto-repeat (used only with AUTO_REPEAT_EN).
- REPEAT_PERIOD, 4, cycles between subsequent auto-repeats (used only with AUTO_REPEAT_EN).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- btn_mode  input  1  raw MODE button, asynchronous, active-high
- btn_inc  input  1  raw INC button, asynchronous, active-high
- mode  output  1  1 while in SET_HOUR or SET_MIN
- change_hour  output  1  level, 1 while in SET_HOUR
- change_min  output  1  level, 1 while in SET_MIN
- valid_response  output  1  single-cycle increment strobe
- set_state  output  2  encoded FSM state: 0 RUN, 1 SET_HOUR, 2 SET_MIN

Behaviour:
- Reset is asynchronous and active-high; clock is `clk`.
  - On reset: state=RUN; mode, change_hour, change_min, valid_response=0; set_state=0.
  - Synchronisers, debounce counters, timeout counter and repeat counter all clear.
  - Reset mid-press: the button is treated as released. A press still held when reset deasserts is not acted on until the debounced level has gone 0 and then 1 again.
- Input path per button:
  - 2-flop synchroniser.
  - Debounce: a counter increments while the synchronised value differs from the debounced level; it clears whenever they match. When it reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - Rising-edge detect on the debounced level gives a 1-cycle press pulse.
- Latency: raw input held steady at 1 -> valid_response high exactly DEBOUNCE_CYCLES+3 clk edges later. Glitches shorter than DEBOUNCE_CYCLES are ignored.
- FSM transitions:
  - RUN: mode press -> SET_HOUR; INC press ignored (no strobe).
  - SET_HOUR: mode press -> SET_MIN; INC press -> valid_response=1 for one cycle, state held.
  - SET_MIN: mode press -> RUN; INC press -> valid_response=1 for one cycle, state held.
  - Timeout: in SET_HOUR or SET_MIN, the idle counter increments each cycle and clears on any press pulse or state change. Reaching TIMEOUT_CYCLES-1 -> RUN on the next edge.
- Outputs are registered and decoded from the next state, so mode, change_hour and change_min are stable in every cycle valid_response is high. A consumer sampling `mode && change_x && valid_response` sees exactly one increment per press.
- Simultaneous MODE and INC press pulses in the same cycle: MODE wins, INC is dropped, no strobe.
- Timeout in the same cycle as an INC press: the press wins, the strobe is issued and the idle counter clears.
- Wrap-around: SET_MIN + mode press -> RUN (never a 4th state). Unused encoding 3 -> RUN.
- valid_response is never high in RUN and never high on two consecutive cycles.
- Counter widths are $clog2(param+1). All counters saturate, none wrap.

Optional Feature:
- Macro: WATCH_SET_AUTO_REPEAT_EN.
- Defined:
  - While debounced INC is held in a SET state, a repeat counter runs.
  - First extra strobe fires REPEAT_DELAY cycles after the initial strobe, then one every REPEAT_PERIOD cycles.
  - Each repeat strobe clears the timeout counter.
  - Release, MODE press, or reset clears the repeat counter.
- Undefined: holding INC yields exactly one strobe; the repeat counter logic is absent.

Decomposition:
- Shared package watch_pkg:
  - set_state_t enum (RUN=0, SET_HOUR=1, SET_MIN=2).
  - Default constants for the debounce, timeout and repeat parameters.
- Sub-module btn_debounce:
  - Contains the synchroniser, debounce counter and edge detect.
  - Parameter DEBOUNCE_CYCLES; outputs `level` and `press`.
  - Instantiated twice (MODE, INC).
- FSM, timeout and repeat logic stay in watch_set_ctrl.

Test Plan:
- Reset released, btn_mode held 1 for 10 cycles -> set_state=1, mode=1, change_hour=1 at edge 7 (DEBOUNCE_CYCLES+3); valid_response stays 0.
- In SET_HOUR, 3 clean INC presses (8 cycles high, 8 low each) -> exactly 3 single-cycle valid_response pulses, each with change_hour=1; a driven hour counter advances 22 -> 23 -> 0 -> 1.
- INC bouncing 1-0-1-0 with 2-cycle pulses -> no strobe; then held 6 cycles -> one strobe.
- MODE presses from RUN -> 1 -> 2 -> 0. In SET_MIN, no input for 64 cycles -> set_state=0 and all outputs 0.
- MODE and INC raised on the same cycle in SET_HOUR -> SET_MIN entered, no valid_response.
- rst asserted mid-press in SET_MIN (asynchronous, between edges) -> outputs 0 immediately. INC still held after release -> no strobe until released and re-pressed. With WATCH_SET_AUTO_REPEAT_EN: INC held 40 cycles in SET_HOUR -> strobes at t0, t0+16, t0+20, …, t0+36.
